// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath constants, pixel type and counter width helper
package cnn_pkg;
  localparam int DATA_W = 16;
  localparam int WIN_K = 3;
  localparam int WIN_TAPS = WIN_K * WIN_K;
  typedef logic signed [DATA_W-1:0] pix_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: circular RAM delaying din by exactly DEPTH enabled cycles
// Ports: clk; en advances the line; din in; dout = din from DEPTH enables ago.
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  import cnn_pkg::cnt_w;
  localparam int PW = cnt_w(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  assign dout = mem[ptr];
  // The >= wrap lets an unreset pointer settle into range on its own.
  always_ff @(posedge clk)
    if (en) begin
      mem[ptr] <= din;
      ptr <= (ptr >= PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming raster-order 3x3 window generator for max pooling
// Ports: clk, rst_n (async, active-low); valid_in/sof/pix_in raster input;
// win0..win8 row-major taps (win8 = newest pixel) with one-cycle valid_out.
// Macro WIN_GEN_STATUS_EN adds frame_done pulse and saturating 16-bit win_count.
module window_gen_3x3 #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic                     sof,
  input  logic signed [DATA_W-1:0] pix_in,
  output logic signed [DATA_W-1:0] win0,
  output logic signed [DATA_W-1:0] win1,
  output logic signed [DATA_W-1:0] win2,
  output logic signed [DATA_W-1:0] win3,
  output logic signed [DATA_W-1:0] win4,
  output logic signed [DATA_W-1:0] win5,
  output logic signed [DATA_W-1:0] win6,
  output logic signed [DATA_W-1:0] win7,
  output logic signed [DATA_W-1:0] win8,
`ifdef WIN_GEN_STATUS_EN
  output logic                     frame_done,
  output logic [15:0]              win_count,
`endif
  output logic                     valid_out
);
  import cnn_pkg::*;
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  logic [CW-1:0] col, cur_c;
  logic [RW-1:0] row, cur_r;
  logic cph, rph, cur_cph, cur_rph, start, col_last, row_last, emit;
  logic signed [DATA_W-1:0] lb1_out, lb2_out;
  logic signed [DATA_W-1:0] top_h [2], mid_h [2], bot_h [2];
  logic signed [DATA_W-1:0] win_r [WIN_TAPS];
  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (.clk(clk), .en(valid_in), .din(pix_in), .dout(lb1_out));
  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb2 (.clk(clk), .en(valid_in), .din(lb1_out), .dout(lb2_out));
  // cph/rph hold the column/row parity so STRIDE=2 needs no modulo.
  always_comb begin
    start = valid_in && sof;
    cur_c = start ? '0 : col;
    cur_r = start ? '0 : row;
    cur_cph = !start && cph;
    cur_rph = !start && rph;
    col_last = cur_c == CW'(IMG_W - 1);
    row_last = cur_r == RW'(IMG_H - 1);
    emit = valid_in && cur_r >= RW'(2) && cur_c >= CW'(2) && (STRIDE == 1 || (!cur_rph && !cur_cph));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      cph <= 1'b0;
      rph <= 1'b0;
      valid_out <= 1'b0;
      win_r <= '{default: '0};
    end else begin
      valid_out <= emit;
      if (valid_in) begin
        col <= col_last ? '0 : cur_c + 1'b1;
        cph <= !col_last && !cur_cph;
        row <= col_last ? (row_last ? '0 : cur_r + 1'b1) : cur_r;
        rph <= col_last ? (!row_last && !cur_rph) : cur_rph;
      end
      if (emit)
        win_r <= '{top_h[0], top_h[1], lb2_out, mid_h[0], mid_h[1], lb1_out, bot_h[0], bot_h[1], pix_in};
    end
  always_ff @(posedge clk)
    if (valid_in) begin
      top_h <= '{top_h[1], lb2_out};
      mid_h <= '{mid_h[1], lb1_out};
      bot_h <= '{bot_h[1], pix_in};
    end
`ifdef WIN_GEN_STATUS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_done <= 1'b0;
      win_count <= '0;
    end else begin
      frame_done <= valid_in && col_last && row_last;
      win_count <= start ? '0 : (valid_out && win_count != 16'hFFFF) ? win_count + 1'b1 : win_count;
    end
`endif
  assign {win0, win1, win2, win3, win4, win5, win6, win7, win8} =
    {win_r[0], win_r[1], win_r[2], win_r[3], win_r[4], win_r[5], win_r[6], win_r[7], win_r[8]};
endmodule
